// File: rtl/updown_sweep_pkg.sv
// Shared encodings for the up/down sweep sequencer: sweep modes and FSM states.
package updown_sweep_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP_UP = 2'b00,
        MODE_WRAP_DN = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN_UP   = 2'b01,
        ST_RUN_DOWN = 2'b10
    } state_t;

endpackage

// File: rtl/updown_sweep_ctrl_core.sv
// Loadable up/down counter register; load takes priority over a step.
module sweep_counter_core #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en) begin
            count <= dir ? count + WIDTH'(1) : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Window sweep sequencer: runs a counter over [lo, hi] in wrap, bounce or one-shot patterns.
// state       | meaning
// ST_IDLE     | stopped, config writes accepted, count holds
// ST_RUN_UP   | sweeping upward on each step_en
// ST_RUN_DOWN | sweeping downward on each step_en
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int DEFAULT_LO = 0,
    parameter int DEFAULT_HI = 7
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic [1:0]       cfg_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             step_en,
    output logic [WIDTH-1:0] count,
    output logic             dir_up,
    output logic             busy,
    output logic             at_limit,
    output logic             done,
    output logic             cfg_err
);

    state_t           state, state_nxt;
    mode_t            mode;
    logic [WIDTH-1:0] lo, hi;
    logic             dir_q, dir_nxt;
    logic             done_q, done_nxt;
    logic             ld, en, step_dir;
    logic [WIDTH-1:0] ld_val;

    sweep_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .clear_n (clear_n),
        .load    (ld),
        .value   (ld_val),
        .en      (en),
        .dir     (step_dir),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state  <= ST_IDLE;
            dir_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            dir_q  <= dir_nxt;
            done_q <= done_nxt;
        end
    end

    // Window registers only move in IDLE, so a running sweep never sees them change.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            lo      <= WIDTH'(DEFAULT_LO);
            hi      <= WIDTH'(DEFAULT_HI);
            mode    <= MODE_WRAP_UP;
            cfg_err <= 1'b0;
        end else if (cfg_we) begin
            if (state != ST_IDLE || cfg_lo > cfg_hi) begin
                cfg_err <= 1'b1;
            end else begin
                lo      <= cfg_lo;
                hi      <= cfg_hi;
                mode    <= mode_t'(cfg_mode);
                cfg_err <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_q;
        done_nxt  = 1'b0;
        ld        = 1'b0;
        ld_val    = count;
        en        = 1'b0;
        step_dir  = dir_q;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ld = 1'b1;
                        if (mode == MODE_WRAP_DN) begin
                            ld_val    = hi;
                            state_nxt = ST_RUN_DOWN;
                            dir_nxt   = 1'b0;
                        end else begin
                            ld_val    = lo;
                            state_nxt = ST_RUN_UP;
                            dir_nxt   = 1'b1;
                        end
                    end
                end
                ST_RUN_UP, ST_RUN_DOWN: begin
                    if (step_en) begin
                        case (mode)
                            MODE_WRAP_UP: begin
                                if (count == hi) begin
                                    ld = 1'b1; ld_val = lo;
                                end else begin
                                    en = 1'b1; step_dir = 1'b1;
                                end
                            end
                            MODE_WRAP_DN: begin
                                if (count == lo) begin
                                    ld = 1'b1; ld_val = hi;
                                end else begin
                                    en = 1'b1; step_dir = 1'b0;
                                end
                            end
                            MODE_BOUNCE: begin
                                // A single-point window has nowhere to bounce to, so it parks.
                                if (lo != hi) begin
                                    en = 1'b1;
                                    if (state == ST_RUN_UP) begin
                                        step_dir = (count != hi);
                                        if (count == hi) begin
                                            state_nxt = ST_RUN_DOWN;
                                            dir_nxt   = 1'b0;
                                        end
                                    end else begin
                                        step_dir = (count == lo);
                                        if (count == lo) begin
                                            state_nxt = ST_RUN_UP;
                                            dir_nxt   = 1'b1;
                                        end
                                    end
                                end
                            end
                            MODE_ONESHOT: begin
                                if (count == hi) begin
                                    done_nxt  = 1'b1;
                                    state_nxt = ST_IDLE;
                                end else begin
                                    en = 1'b1; step_dir = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        at_limit = (state == ST_RUN_UP && count == hi) ||
                   (state == ST_RUN_DOWN && count == lo);
    end

    assign dir_up = dir_q;
    assign done   = done_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl with hand-computed expected sequences.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       clear_n, cfg_we, start, stop, step_en;
    logic [2:0] cfg_lo, cfg_hi;
    logic [1:0] cfg_mode;
    logic [2:0] count;
    logic       dir_up, busy, at_limit, done, cfg_err;
    int         tests = 0;
    int         fails = 0;

    updown_sweep_ctrl #(.WIDTH(3), .DEFAULT_LO(0), .DEFAULT_HI(7)) dut (
        .clk(clk), .clear_n(clear_n), .cfg_we(cfg_we), .cfg_lo(cfg_lo),
        .cfg_hi(cfg_hi), .cfg_mode(cfg_mode), .start(start), .stop(stop),
        .step_en(step_en), .count(count), .dir_up(dir_up), .busy(busy),
        .at_limit(at_limit), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [2:0] l, input logic [2:0] h, input logic [1:0] m);
        cfg_we = 1'b1; cfg_lo = l; cfg_hi = h; cfg_mode = m;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        clear_n = 1'b0; cfg_we = 0; start = 0; stop = 0; step_en = 0;
        cfg_lo = 0; cfg_hi = 0; cfg_mode = 0;
        tick(); tick();
        clear_n = 1'b1;
        tick();
        tests++;
        if (count !== 3'd0 || busy !== 1'b0 || dir_up !== 1'b1 || cfg_err !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset: count=%0d busy=%b dir=%b err=%b done=%b, want 0 0 1 0 0",
                     count, busy, dir_up, cfg_err, done);
        end
    endtask

    task automatic test_wrap_up();
        logic [2:0] exp_c [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd3};
        do_cfg(3'd2, 3'd5, 2'b00);
        start = 1'b1; tick(); start = 1'b0;
        step_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (count !== exp_c[i] || at_limit !== (exp_c[i] == 3'd5) || busy !== 1'b1) begin
                fails++;
                $display("FAIL wrap_up[%0d]: count=%0d at_limit=%b busy=%b, want %0d %b 1",
                         i, count, at_limit, busy, exp_c[i], exp_c[i] == 3'd5);
            end
            tick();
        end
        step_en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_wrap_down_full();
        do_cfg(3'd0, 3'd7, 2'b01);
        start = 1'b1; tick(); start = 1'b0;
        tests++;
        if (count !== 3'd7 || dir_up !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL wrap_dn_load: count=%0d dir=%b busy=%b, want 7 0 1", count, dir_up, busy);
        end
        step_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        tests++;
        if (count !== 3'd0 || at_limit !== 1'b1) begin
            fails++;
            $display("FAIL wrap_dn_bottom: count=%0d at_limit=%b, want 0 1", count, at_limit);
        end
        tick();
        tests++;
        if (count !== 3'd7 || at_limit !== 1'b0) begin
            fails++;
            $display("FAIL wrap_dn_wrap: count=%0d at_limit=%b, want 7 0", count, at_limit);
        end
        step_en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_bounce();
        logic [2:0] exp_c [6] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd2};
        logic       exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_cfg(3'd1, 3'd3, 2'b10);
        start = 1'b1; tick(); start = 1'b0;
        step_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (count !== exp_c[i] || dir_up !== exp_d[i]) begin
                fails++;
                $display("FAIL bounce[%0d]: count=%0d dir=%b, want %0d %b",
                         i, count, dir_up, exp_c[i], exp_d[i]);
            end
            tick();
        end
        step_en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
        do_cfg(3'd3, 3'd3, 2'b10);
        start = 1'b1; tick(); start = 1'b0;
        step_en = 1'b1; tick(); tick(); step_en = 1'b0;
        tests++;
        if (count !== 3'd3 || dir_up !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL bounce_point: count=%0d dir=%b busy=%b, want 3 1 1", count, dir_up, busy);
        end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_oneshot();
        do_cfg(3'd0, 3'd7, 2'b11);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step_en = 1'b1; tick();
            step_en = 1'b0; tick();
            tests++;
            if (count !== 3'(i) || done !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL oneshot_step[%0d]: count=%0d done=%b busy=%b, want %0d 0 1",
                         i, count, done, busy, i);
            end
        end
        step_en = 1'b1; tick(); step_en = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 3'd7) begin
            fails++;
            $display("FAIL oneshot_done: done=%b busy=%b count=%0d, want 1 0 7", done, busy, count);
        end
        tick();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_pulse_width: done=%b, want 0", done);
        end
        step_en = 1'b1; tick(); tick(); step_en = 1'b0;
        tests++;
        if (count !== 3'd7 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_idle_step: count=%0d busy=%b done=%b, want 7 0 0", count, busy, done);
        end
    endtask

    task automatic test_cfg_err();
        do_cfg(3'd6, 3'd2, 2'b00);
        tests++;
        if (cfg_err !== 1'b1) begin
            fails++;
            $display("FAIL cfg_err_order: cfg_err=%b, want 1", cfg_err);
        end
        // Limits and mode must still be lo=0 hi=7 one-shot from the previous test.
        start = 1'b1; tick(); start = 1'b0;
        tests++;
        if (count !== 3'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL cfg_err_kept: count=%0d busy=%b, want 0 1", count, busy);
        end
        cfg_we = 1'b1; cfg_lo = 3'd4; cfg_hi = 3'd5; cfg_mode = 2'b01; step_en = 1'b1;
        tick();
        cfg_we = 1'b0;
        tick();
        step_en = 1'b0;
        tests++;
        if (cfg_err !== 1'b1 || count !== 3'd2 || busy !== 1'b1 || dir_up !== 1'b1) begin
            fails++;
            $display("FAIL cfg_err_busy: err=%b count=%0d busy=%b dir=%b, want 1 2 1 1",
                     cfg_err, count, busy, dir_up);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        do_cfg(3'd2, 3'd6, 2'b00);
        start = 1'b1; tick(); start = 1'b0;
        tests++;
        if (cfg_err !== 1'b0 || count !== 3'd2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL cfg_valid: err=%b count=%0d busy=%b, want 0 2 1", cfg_err, count, busy);
        end
    endtask

    task automatic test_priority();
        step_en = 1'b1; tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0; step_en = 1'b0;
        tests++;
        if (busy !== 1'b0 || count !== 3'd4 || done !== 1'b0) begin
            fails++;
            $display("FAIL stop_vs_step: busy=%b count=%0d done=%b, want 0 4 0", busy, count, done);
        end
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        tests++;
        if (busy !== 1'b0 || count !== 3'd4) begin
            fails++;
            $display("FAIL stop_vs_start: busy=%b count=%0d, want 0 4", busy, count);
        end
        start = 1'b1; tick(); start = 1'b0;
        step_en = 1'b1; tick(); tick(); step_en = 1'b0;
        tests++;
        if (count !== 3'd4 || busy !== 1'b1) begin
            fails++;
            $display("FAIL restart: count=%0d busy=%b, want 4 1", count, busy);
        end
        clear_n = 1'b0; tick(); clear_n = 1'b1;
        tests++;
        if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || dir_up !== 1'b1) begin
            fails++;
            $display("FAIL midsweep_reset: count=%0d busy=%b done=%b dir=%b, want 0 0 0 1",
                     count, busy, done, dir_up);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down_full();
        test_bounce();
        test_oneshot();
        test_cfg_err();
        test_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
